vmu_chan_ctrl: RTL and testbench

VMU_CHAN_CTRL -- requirements
Module: vmu_chan_ctrl

---
 rtl/vmu_pkg.sv | 38 +++
 rtl/vmu_chan_ctrl_if.sv | 30 +++
 rtl/vmu_agen.sv | 102 ++++++++++
 rtl/vmu_chan_ctrl.sv | 131 +++++++++++++
 tb/tb_vmu_chan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vmu_pkg.sv
// vmu_pkg: shared opcode, config-select and FSM state constants for the VMU
// channel controller and its address generators.
package vmu_pkg;

  // Selects what an accepted op does: run a load/store op or write one CSR
  typedef enum logic [1:0] {
    CFG_LS     = 2'b00,
    CFG_VLEN   = 2'b01,
    CFG_STRIDE = 2'b10,
    CFG_CHMASK = 2'b11
  } cfg_e;

  // Per-channel load/store opcode; bit0 reads the SPM, bit1 writes it
  typedef enum logic [1:0] {
    LS_NOP   = 2'b00,
    LS_LOAD  = 2'b01,
    LS_STORE = 2'b10,
    LS_COPY  = 2'b11
  } ls_op_e;

  // Controller sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_END  = 2'b10
  } state_e;

  // True when the opcode needs an SPM read each beat
  function automatic logic op_reads(input logic [1:0] op);
    return (op == LS_LOAD) || (op == LS_COPY);
  endfunction

  // True when the opcode needs an SPM write each beat
  function automatic logic op_writes(input logic [1:0] op);
    return (op == LS_STORE) || (op == LS_COPY);
  endfunction

endpackage

// File: rtl/vmu_chan_ctrl_if.sv
// vmu_chan_ctrl_if: op handshake, CSR write data and per-channel SPM
// read/write port bundle between the sequencer and the channel controller.
interface vmu_chan_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32
);
  logic                     i_op_vld;
  logic                     o_op_rdy;
  logic [1:0]               i_op_cfg;
  logic [ADDR_W-1:0]        i_cfg_scalar;
  logic [NUM_CH*2-1:0]      i_ls_op;
  logic [NUM_CH*ADDR_W-1:0] i_ls_base;
  logic                     i_abort;
  logic [NUM_CH-1:0]        o_rden;
  logic [NUM_CH-1:0]        o_wren;
  logic [NUM_CH*ADDR_W-1:0] o_rdaddr;
  logic [NUM_CH*ADDR_W-1:0] o_wraddr;
  logic                     o_busy;
  logic                     o_done;

  modport master (
    output i_op_vld, i_op_cfg, i_cfg_scalar, i_ls_op, i_ls_base, i_abort,
    input  o_op_rdy, o_rden, o_wren, o_rdaddr, o_wraddr, o_busy, o_done
  );

  modport slave (
    input  i_op_vld, i_op_cfg, i_cfg_scalar, i_ls_op, i_ls_base, i_abort,
    output o_op_rdy, o_rden, o_wren, o_rdaddr, o_wraddr, o_busy, o_done
  );
endinterface

// File: rtl/vmu_agen.sv
// vmu_agen: one channel's SPM address generator. Produces base + k*stride
// for beat k as registered read/write enables and addresses.
// Optional feature macro: VMU_ADDR_WRAP_EN -- when defined, addresses keep
// only the low SPM_AW bits (wrap modulo 2^SPM_AW); otherwise full ADDR_W.
module vmu_agen #(
  parameter int ADDR_W = 32,
  parameter int SPM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_stride,
  output logic              o_rden,
  output logic              o_wren,
  output logic [ADDR_W-1:0] o_rdaddr,
  output logic [ADDR_W-1:0] o_wraddr
);
`ifdef VMU_ADDR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  localparam int EFF_AW = (WRAP_EN && (SPM_AW < ADDR_W)) ? SPM_AW : ADDR_W;

  function automatic logic [ADDR_W-1:0] low_mask(input int bits);
    logic [ADDR_W-1:0] m;
    m = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (b < bits) m[b] = 1'b1;
      else          m[b] = 1'b0;
    end
    return m;
  endfunction

  localparam logic [ADDR_W-1:0] ADDR_MASK = low_mask(EFF_AW);

  logic              r_rd, r_wr;
  logic [ADDR_W-1:0] r_next;
  logic              r_rden, r_wren;
  logic [ADDR_W-1:0] r_rdaddr, r_wraddr;
  logic              w_rd, w_wr;
  logic [ADDR_W-1:0] w_addr;

  // Pick this beat's enables/address: the fresh op on start, the latched op on a step
  always_comb begin
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_addr = '0;
    if (i_start) begin
      w_rd   = i_rd;
      w_wr   = i_wr;
      w_addr = i_base & ADDR_MASK;
    end else if (i_step) begin
      w_rd   = r_rd;
      w_wr   = r_wr;
      w_addr = r_next & ADDR_MASK;
    end else begin
      w_rd   = 1'b0;
      w_wr   = 1'b0;
      w_addr = '0;
    end
  end

  // Latch the op, advance the running address (carry out is dropped), register outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_next   <= '0;
      r_rden   <= 1'b0;
      r_wren   <= 1'b0;
      r_rdaddr <= '0;
      r_wraddr <= '0;
    end else begin
      r_rden   <= w_rd;
      r_wren   <= w_wr;
      r_rdaddr <= w_rd ? w_addr : '0;
      r_wraddr <= w_wr ? w_addr : '0;
      if (i_start) begin
        r_rd   <= i_rd;
        r_wr   <= i_wr;
        r_next <= i_base + i_stride;
      end else if (i_step) begin
        r_next <= r_next + i_stride;
      end else begin
        r_rd   <= 1'b0;
        r_wr   <= 1'b0;
        r_next <= '0;
      end
    end
  end

  assign o_rden   = r_rden;
  assign o_wren   = r_wren;
  assign o_rdaddr = r_rdaddr;
  assign o_wraddr = r_wraddr;

endmodule

// File: rtl/vmu_chan_ctrl.sv
// vmu_chan_ctrl: accepts ops from the sequencer, holds the VLEN/STRIDE/CHMASK
// CSRs and runs VLEN one-cycle beats across all LSU channels (IDLE/BUSY/END).
// Optional feature macro: VMU_ADDR_WRAP_EN (SPM address wrap, see vmu_agen).
module vmu_chan_ctrl
  import vmu_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 10,
  parameter int SPM_AW = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  vmu_chan_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]    r_vlen;
  logic [ADDR_W-1:0]   r_stride;
  logic [NUM_CH-1:0]   r_chmask;
  logic                r_busy, r_done;
  logic                w_accept, w_start, w_step, w_last;
  logic [NUM_CH-1:0]   w_rden, w_wren;
  logic [NUM_CH*ADDR_W-1:0] w_rdaddr, w_wraddr;

  // Abort blocks acceptance in the same cycle, so it also protects the CSRs
  assign bus.o_op_rdy = (r_state == ST_IDLE) && !bus.i_abort;
  assign w_accept     = bus.i_op_vld && bus.o_op_rdy;
  assign w_last       = (r_cnt == (r_vlen - CNT_ONE));

  // Next state, beat counter and address-generator control
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_start     = 1'b0;
    w_step      = 1'b0;
    if (bus.i_abort) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (cfg_e'(bus.i_op_cfg) == CFG_LS)) begin
            w_cnt_nxt = '0;
            if (r_vlen != '0) begin
              w_state_nxt = ST_BUSY;
              w_start     = 1'b1;
            end else begin
              w_state_nxt = ST_END;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (w_last) begin
            w_state_nxt = ST_END;
          end else begin
            w_step    = 1'b1;
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ST_END:  w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, beat counter and the busy/done outputs, all aligned to the new state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_END);
    end
  end

  // Configuration CSRs, written only by an accepted non-load/store op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vlen   <= CNT_ONE;
      r_stride <= {{(ADDR_W-1){1'b0}}, 1'b1};
      r_chmask <= '1;
    end else if (w_accept) begin
      case (cfg_e'(bus.i_op_cfg))
        CFG_VLEN:   r_vlen   <= bus.i_cfg_scalar[CNT_W-1:0];
        CFG_STRIDE: r_stride <= bus.i_cfg_scalar;
        CFG_CHMASK: r_chmask <= bus.i_cfg_scalar[NUM_CH-1:0];
        default:    r_vlen   <= r_vlen;
      endcase
    end else begin
      r_vlen <= r_vlen;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    vmu_agen #(
      .ADDR_W (ADDR_W),
      .SPM_AW (SPM_AW)
    ) u_agen (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_start),
      .i_step   (w_step),
      .i_rd     (op_reads(bus.i_ls_op[2*c +: 2]) && r_chmask[c]),
      .i_wr     (op_writes(bus.i_ls_op[2*c +: 2]) && r_chmask[c]),
      .i_base   (bus.i_ls_base[c*ADDR_W +: ADDR_W]),
      .i_stride (r_stride),
      .o_rden   (w_rden[c]),
      .o_wren   (w_wren[c]),
      .o_rdaddr (w_rdaddr[c*ADDR_W +: ADDR_W]),
      .o_wraddr (w_wraddr[c*ADDR_W +: ADDR_W])
    );
  end

  assign bus.o_rden   = w_rden;
  assign bus.o_wren   = w_wren;
  assign bus.o_rdaddr = w_rdaddr;
  assign bus.o_wraddr = w_wraddr;
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;

endmodule

// File: tb/tb_vmu_chan_ctrl.sv
// tb_vmu_chan_ctrl: randomized and directed stimulus against a queue-based
// schedule model of the channel controller; one compare process per cycle.
module tb_vmu_chan_ctrl;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 10;
  localparam int SPM_AW = 12;
  localparam int AW_ALL = NUM_CH * ADDR_W;

  typedef logic [127:0] w_t;
  typedef struct packed {
    logic [NUM_CH-1:0] rden;
    logic [NUM_CH-1:0] wren;
    logic [AW_ALL-1:0] rdaddr;
    logic [AW_ALL-1:0] wraddr;
    logic              busy;
    logic              done;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_on   = 1'b0;

  // model state: CSRs and the remaining per-cycle output schedule
  logic [CNT_W-1:0]  m_vlen;
  logic [ADDR_W-1:0] m_stride;
  logic [NUM_CH-1:0] m_mask;
  exp_t              q[$];
  exp_t              cur = '0;

  vmu_chan_ctrl_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W)) bus();

  vmu_chan_ctrl #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .SPM_AW(SPM_AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vlen   = 10'd1;
    m_stride = 32'd1;
    m_mask   = 4'hF;
    q.delete();
    cur = '0;
  endtask

  // expected outputs for beat k: address = base + k*stride, modulo 2^32 (or 2^SPM_AW)
  function automatic exp_t beat(input int k, input logic [2*NUM_CH-1:0] op,
                                input logic [AW_ALL-1:0] base);
    exp_t e;
    logic [63:0] full;
    logic [ADDR_W-1:0] a;
    logic rd, wr;
    e = '0;
    e.busy = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      full = 64'(base[c*ADDR_W +: ADDR_W]) + 64'(m_stride) * 64'(k);
`ifdef VMU_ADDR_WRAP_EN
      full = full % (64'd1 << SPM_AW);
`endif
      a  = full[ADDR_W-1:0];
      rd = op[2*c] && m_mask[c];
      wr = op[2*c+1] && m_mask[c];
      e.rden[c] = rd;
      e.wren[c] = wr;
      e.rdaddr[c*ADDR_W +: ADDR_W] = rd ? a : 32'd0;
      e.wraddr[c*ADDR_W +: ADDR_W] = wr ? a : 32'd0;
    end
    return e;
  endfunction

  // advance the model by one clock edge given the inputs held during that cycle
  task automatic model_step(input logic vld, input logic [1:0] cfg, input logic [ADDR_W-1:0] sc,
                            input logic [2*NUM_CH-1:0] op, input logic [AW_ALL-1:0] base,
                            input logic ab);
    exp_t e;
    logic acc;
    acc = vld && !cur.busy && !ab;
    if (ab) begin
      q.delete();
      cur = '0;
    end else if (acc && cfg != 2'b00) begin
      if (cfg == 2'b01) m_vlen = sc[CNT_W-1:0];
      if (cfg == 2'b10) m_stride = sc;
      if (cfg == 2'b11) m_mask = sc[NUM_CH-1:0];
      cur = '0;
    end else if (acc) begin
      for (int k = 0; k < int'(m_vlen); k++) q.push_back(beat(k, op, base));
      e = '0;
      e.busy = 1'b1;
      e.done = 1'b1;
      q.push_back(e);
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
  endtask

  task automatic do_cycle(input logic vld, input logic [1:0] cfg, input logic [ADDR_W-1:0] sc,
                          input logic [2*NUM_CH-1:0] op, input logic [AW_ALL-1:0] base,
                          input logic ab);
    bus.i_op_vld     = vld;
    bus.i_op_cfg     = cfg;
    bus.i_cfg_scalar = sc;
    bus.i_ls_op      = op;
    bus.i_ls_base    = base;
    bus.i_abort      = ab;
    @(posedge clk);
    model_step(vld, cfg, sc, op, base, ab);
    #1;
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, 2'b00, 32'd0, 8'h00, 128'd0, 1'b0);
  endtask

  task automatic set_csr(input logic [1:0] cfg, input logic [ADDR_W-1:0] v);
    do_cycle(1'b1, cfg, v, 8'h00, 128'd0, 1'b0);
  endtask

  task automatic ls(input logic [2*NUM_CH-1:0] op, input logic [AW_ALL-1:0] base);
    do_cycle(1'b1, 2'b00, 32'd0, op, base, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && cur.busy; i++) idle_cycle();
    idle_cycle();
    chk("drain_idle", w_t'(bus.o_busy), w_t'(1'b0));
  endtask

  // compare every cycle, mid-cycle, against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy",   w_t'(bus.o_busy),   w_t'(cur.busy));
      chk("done",   w_t'(bus.o_done),   w_t'(cur.done));
      chk("rden",   w_t'(bus.o_rden),   w_t'(cur.rden));
      chk("wren",   w_t'(bus.o_wren),   w_t'(cur.wren));
      chk("rdaddr", w_t'(bus.o_rdaddr), w_t'(cur.rdaddr));
      chk("wraddr", w_t'(bus.o_wraddr), w_t'(cur.wraddr));
      chk("op_rdy", w_t'(bus.o_op_rdy), w_t'(!cur.busy && !bus.i_abort));
    end
  end

  initial begin
    logic [31:0] exp37 [4];
    logic [31:0] expw  [4];
    int          cnt;
    logic [7:0]  op8;
    logic [1:0]  cfg;
    logic [31:0] sc;
    int          r;

    exp37 = '{32'h100, 32'h102, 32'h104, 32'h106};
`ifdef VMU_ADDR_WRAP_EN
    expw  = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};
`else
    expw  = '{32'hFFE, 32'hFFF, 32'h1000, 32'h1001};
`endif
    bus.i_op_vld = 1'b0; bus.i_op_cfg = 2'b00; bus.i_cfg_scalar = 32'd0;
    bus.i_ls_op = 8'h00; bus.i_ls_base = 128'd0; bus.i_abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", w_t'(bus.o_busy), w_t'(1'b0));
    chk("rst_done", w_t'(bus.o_done), w_t'(1'b0));
    chk("rst_en",   w_t'({bus.o_rden, bus.o_wren}), w_t'(8'h00));
    chk("rst_addr", w_t'(bus.o_rdaddr | bus.o_wraddr), w_t'(128'd0));
    rst_n = 1'b1;
    #1;
    chk("rst_rdy", w_t'(bus.o_op_rdy), w_t'(1'b1));
    model_reset();
    chk_on = 1'b1;

    // VLEN=4 STRIDE=2, ch0 load at 0x100
    set_csr(2'b01, 32'd4);
    set_csr(2'b10, 32'd2);
    ls(8'h01, 128'h100);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) idle_cycle();
      chk("b37_addr", w_t'(bus.o_rdaddr[31:0]), w_t'(exp37[k]));
      chk("b37_rden", w_t'(bus.o_rden), w_t'(4'b0001));
    end
    idle_cycle();
    chk("b37_done", w_t'(bus.o_done), w_t'(1'b1));
    chk("b37_end_en", w_t'(bus.o_rden), w_t'(4'b0000));
    idle_cycle();
    chk("b37_done_off", w_t'({bus.o_done, bus.o_busy}), w_t'(2'b00));

    // CHMASK=0101, all channels copy
    set_csr(2'b11, 32'h5);
    ls(8'hFF, {32'h4000, 32'h3000, 32'h2000, 32'h1000});
    chk("m38_rden", w_t'(bus.o_rden), w_t'(4'b0101));
    chk("m38_wren", w_t'(bus.o_wren), w_t'(4'b0101));
    chk("m38_rdaddr", w_t'(bus.o_rdaddr), w_t'({32'h0, 32'h3000, 32'h0, 32'h1000}));
    chk("m38_wraddr", w_t'(bus.o_wraddr), w_t'({32'h0, 32'h3000, 32'h0, 32'h1000}));
    drain();
    set_csr(2'b11, 32'hF);

    // VLEN=0: straight to END, no enables
    set_csr(2'b01, 32'd0);
    ls(8'h01, 128'h100);
    chk("v0_done", w_t'(bus.o_done), w_t'(1'b1));
    chk("v0_rden", w_t'(bus.o_rden), w_t'(4'b0000));
    idle_cycle();
    chk("v0_after", w_t'({bus.o_done, bus.o_busy}), w_t'(2'b00));

    // abort on beat 2 of 8
    set_csr(2'b01, 32'd8);
    ls(8'h01, 128'h100);
    idle_cycle();
    idle_cycle();
    chk("ab_beat2", w_t'(bus.o_rdaddr[31:0]), w_t'(32'h104));
    do_cycle(1'b0, 2'b00, 32'd0, 8'h00, 128'd0, 1'b1);
    chk("ab_en", w_t'({bus.o_rden, bus.o_wren}), w_t'(8'h00));
    chk("ab_state", w_t'({bus.o_done, bus.o_busy}), w_t'(2'b00));
    idle_cycle();
    chk("ab_rdy", w_t'(bus.o_op_rdy), w_t'(1'b1));
    repeat (4) idle_cycle();

    // op while busy is ignored; abort beats a simultaneous op
    ls(8'h02, 128'h200);
    idle_cycle();
    set_csr(2'b01, 32'd3);
    chk("busy_rdy", w_t'(bus.o_op_rdy), w_t'(1'b0));
    drain();
    do_cycle(1'b1, 2'b01, 32'd2, 8'h00, 128'd0, 1'b1);
    chk("abpri_rdy", w_t'(bus.o_op_rdy), w_t'(1'b0));
    idle_cycle();
    ls(8'h01, 128'h40);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.o_rden[0]) cnt++;
      idle_cycle();
    end
    chk("vlen_kept", w_t'(cnt), w_t'(8));

    // address wrap / no-wrap at 0xFFE
    set_csr(2'b01, 32'd4);
    set_csr(2'b10, 32'd1);
    ls(8'h01, 128'hFFE);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) idle_cycle();
      chk("wrap_addr", w_t'(bus.o_rdaddr[31:0]), w_t'(expw[k]));
    end
    drain();

    // reset in the middle of an op
    ls(8'h03, 128'h500);
    idle_cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", w_t'(bus.o_busy), w_t'(1'b0));
    chk("mid_rst_en", w_t'({bus.o_rden, bus.o_wren}), w_t'(8'h00));
    chk("mid_rst_addr", w_t'(bus.o_rdaddr), w_t'(128'd0));
    model_reset();
    bus.i_op_vld = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    idle_cycle();
    ls(8'h01, 128'h10);
    idle_cycle();
    chk("post_rst_beat1", w_t'(bus.o_done), w_t'(1'b1));

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      cfg = 2'b00;
      else if (r < 8) cfg = 2'b01;
      else if (r < 9) cfg = 2'b10;
      else            cfg = 2'b11;
      if (cfg == 2'b01)      sc = 32'($urandom_range(0, 6));
      else if (cfg == 2'b11) sc = 32'($urandom_range(0, 15));
      else if ($urandom_range(0, 1) == 1) sc = $urandom();
      else                   sc = 32'($urandom_range(0, 8));
      op8 = 8'($urandom());
      do_cycle(($urandom_range(0, 1) == 1), cfg, sc, op8,
               {$urandom(), $urandom(), $urandom(), $urandom()},
               ($urandom_range(0, 24) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
